// File: rtl/execute_cycle.sv
// RV32I execute stage: operand select, ALU, branch resolve, squash, E/M register.
// Optional operand forwarding muxes are enabled by defining FORWARD_EN.
module execute_cycle #(
    parameter int SQUASH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RD_E,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCPlus4M
);

    localparam logic [1:0] SQ_LOAD = 2'(SQUASH_CYCLES);

    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        zero;
    logic [1:0]  sq;
    logic        squash_active;

`ifdef FORWARD_EN
    always_comb begin
        unique case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = ALUResultM;
            default: src_a = RD1_E;
        endcase
    end

    always_comb begin
        unique case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALUResultM;
            default: fwd_b = RD2_E;
        endcase
    end
`else
    logic unused_fwd;

    assign src_a      = RD1_E;
    assign fwd_b      = RD2_E;
    assign unused_fwd = ^{ForwardAE, ForwardBE, ResultW};
`endif

    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    always_comb begin
        alu_result = '0;
        unique case (ALUControlE)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b101:  alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
            default: alu_result = '0;
        endcase
    end

    assign zero          = (alu_result == 32'd0);
    assign squash_active = (sq != 2'd0);
    assign PCSrcE        = BranchE & zero & ~squash_active;
    assign PCTargetE     = PCE + Imm_Ext_E;

    // Squashed slots keep their data but never commit a register or memory write.
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            sq         <= '0;
        end else if (en) begin
            RegWriteM  <= RegWriteE & ~squash_active;
            MemWriteM  <= MemWriteE & ~squash_active;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= alu_result;
            WriteDataM <= fwd_b;
            PCPlus4M   <= PCPlus4E;
            if (PCSrcE)
                sq <= SQ_LOAD;
            else if (squash_active)
                sq <= sq - 2'd1;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Randomized bench for execute_cycle against a behavioural model,
// plus directed scenarios with literal expectations.
module tb_execute_cycle;

    localparam int SQ_N = 2;

    logic        clk;
    logic        rst;
    logic        en;
    logic        RegWriteE;
    logic        ALUSrcE;
    logic        MemWriteE;
    logic        ResultSrcE;
    logic        BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Imm_Ext_E;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] ResultW;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;

    execute_cycle #(.SQUASH_CYCLES(SQ_N)) dut (
        .clk(clk), .rst(rst), .en(en),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .RD_E(RD_E),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RD_M(RD_M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: what the M outputs must hold, and squash slots remaining.
    logic        m_init = 1'b0;
    logic        m_rw, m_mw, m_rs, m_known;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wd, m_pc4;
    int          m_left;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel,
                                         input logic [31:0] rd);
`ifdef FORWARD_EN
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return m_alu;
`endif
        return rd;
    endfunction

    function automatic logic [31:0] exp_alu();
        logic [31:0] b;
        b = ALUSrcE ? Imm_Ext_E : pick(ForwardBE, RD2_E);
        return alu_ref(ALUControlE, pick(ForwardAE, RD1_E), b);
    endfunction

    function automatic logic exp_pcsrc();
        return BranchE && exp_alu() == 32'd0 && m_left == 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic sqd;
        m_init <= 1'b1;
        if (rst) begin
            {m_rw, m_mw, m_rs} <= 3'b000;
            m_rd    <= '0;
            m_alu   <= '0;
            m_wd    <= '0;
            m_pc4   <= '0;
            m_known <= 1'b1;
            m_left  <= 0;
        end else if (en) begin
            sqd = (m_left > 0);
            m_rw    <= RegWriteE && !sqd;
            m_mw    <= MemWriteE && !sqd;
            m_rs    <= ResultSrcE;
            m_rd    <= RD_E;
            m_alu   <= exp_alu();
            m_wd    <= pick(ForwardBE, RD2_E);
            m_pc4   <= PCPlus4E;
            m_known <= !sqd;
            if (exp_pcsrc())
                m_left <= SQ_N;
            else if (sqd)
                m_left <= m_left - 1;
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            chk("PCSrcE", {31'b0, PCSrcE}, {31'b0, exp_pcsrc()});
            chk("PCTargetE", PCTargetE, PCE + Imm_Ext_E);
            chk("RegWriteM", {31'b0, RegWriteM}, {31'b0, m_rw});
            chk("MemWriteM", {31'b0, MemWriteM}, {31'b0, m_mw});
            if (m_known) begin
                chk("ResultSrcM", {31'b0, ResultSrcM}, {31'b0, m_rs});
                chk("RD_M", {27'b0, RD_M}, {27'b0, m_rd});
                chk("ALUResultM", ALUResultM, m_alu);
                chk("WriteDataM", WriteDataM, m_wd);
                chk("PCPlus4M", PCPlus4M, m_pc4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b1; RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0;
        BranchE = 0; ALUSrcE = 0; ALUControlE = 3'd0;
        ForwardAE = 0; ForwardBE = 0;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
        PCE = 32'h100; PCPlus4E = 32'h104; ResultW = 0;
    endtask

    task automatic alu_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic rw);
        idle();
        ALUControlE = op; RD1_E = a; RD2_E = b;
        RegWriteE = rw; RD_E = 5'd3;
    endtask

    task automatic branch_taken();
        idle();
        BranchE = 1; ALUControlE = 3'd1;
        RD1_E = 32'd9; RD2_E = 32'd9;
        PCE = 32'h40; Imm_Ext_E = 32'h10;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        RD1_E = $urandom; RD2_E = $urandom; RegWriteE = 1; MemWriteE = 1;
        tick();
        chk("rst RegWriteM", {31'b0, RegWriteM}, 32'd0);
        chk("rst ALUResultM", ALUResultM, 32'd0);
        chk("rst PCPlus4M", PCPlus4M, 32'd0);
        chk("rst PCSrcE", {31'b0, PCSrcE}, 32'd0);
        tick();
        rst = 1'b0;

        alu_op(3'd0, 32'd5, 32'd7, 1'b1);
        tick();
        chk("add ALUResultM", ALUResultM, 32'd12);
        chk("add RD_M", {27'b0, RD_M}, 32'd3);
        chk("add RegWriteM", {31'b0, RegWriteM}, 32'd1);
        alu_op(3'd1, 32'd5, 32'd7, 1'b1);
        tick();
        chk("sub ALUResultM", ALUResultM, 32'hFFFF_FFFE);

        alu_op(3'd0, 32'd60, 32'd40, 1'b1);
        tick();
        chk("pre-fwd ALUResultM", ALUResultM, 32'd100);
        alu_op(3'd0, 32'd1, 32'd2, 1'b1);
        ResultW = 32'd200; ForwardAE = 2'b10; ForwardBE = 2'b01;
        tick();
`ifdef FORWARD_EN
        chk("fwd ALUResultM", ALUResultM, 32'd300);
        chk("fwd WriteDataM", WriteDataM, 32'd200);
`else
        chk("nofwd ALUResultM", ALUResultM, 32'd3);
        chk("nofwd WriteDataM", WriteDataM, 32'd2);
`endif

        branch_taken();
        #1;
        chk("br PCSrcE", {31'b0, PCSrcE}, 32'd1);
        chk("br PCTargetE", PCTargetE, 32'h50);
        tick();
        for (int i = 0; i < 3; i++) begin
            alu_op(3'd0, i, 1, 1'b1);
            tick();
            chk("squash RegWriteM", {31'b0, RegWriteM}, (i == 2) ? 1 : 0);
        end

        branch_taken();
        tick();
        idle();
        en = 1'b0; RegWriteE = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold RegWriteM", {31'b0, RegWriteM}, 32'd0);
            chk("hold PCPlus4M", PCPlus4M, 32'h104);
        end
        for (int i = 0; i < 3; i++) begin
            alu_op(3'd0, i, 2, 1'b1);
            tick();
            chk("resume RegWriteM", {31'b0, RegWriteM}, (i == 2) ? 1 : 0);
        end

        branch_taken();
        tick();
        branch_taken();
        RegWriteE = 1;
        #1;
        chk("win PCSrcE", {31'b0, PCSrcE}, 32'd0);
        tick();
        chk("win slot1 RegWriteM", {31'b0, RegWriteM}, 32'd0);
        alu_op(3'd0, 32'd4, 32'd4, 1'b1);
        tick();
        chk("win slot2 RegWriteM", {31'b0, RegWriteM}, 32'd0);
        alu_op(3'd0, 32'd4, 32'd4, 1'b1);
        tick();
        chk("win end RegWriteM", {31'b0, RegWriteM}, 32'd1);

        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            en = ($urandom_range(0, 3) != 0);
            RegWriteE = $urandom; MemWriteE = $urandom;
            ResultSrcE = $urandom; ALUSrcE = $urandom;
            BranchE = ($urandom_range(0, 2) == 0);
            ALUControlE = $urandom;
            RD1_E = $urandom; RD2_E = $urandom;
            Imm_Ext_E = $urandom; PCE = $urandom; PCPlus4E = $urandom;
            RD_E = $urandom; ResultW = $urandom;
            ForwardAE = $urandom; ForwardBE = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                RD1_E = $urandom_range(0, 3);
                RD2_E = $urandom_range(0, 3);
            end
            if (BranchE && $urandom_range(0, 1) == 1) begin
                ALUControlE = 3'd1; ALUSrcE = 0;
                ForwardAE = 0; ForwardBE = 0; RD2_E = RD1_E;
            end
            if (!m_known) begin
                if (ForwardAE == 2'd2) ForwardAE = 2'd0;
                if (ForwardBE == 2'd2) ForwardBE = 2'd0;
            end
            tick();
        end
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
